// File: rtl/vga_dither_pkg.sv
// Shared constants and helpers for the 3-bit VGA dither output stage.
//   BAYER4  : 4x4 ordered-dither matrix (0..15); the stage uses it >> 1.
//   CW_IN   : colour width arriving from the mixer.
//   CW_OUT  : colour width per channel on the VGA pins.
//   sat_add : colour + threshold, clamped to the full-scale input code.
package vga_dither_pkg;

    localparam int CW_IN  = 6;
    localparam int CW_OUT = 3;

    // Indexed [y_ph][x_ph].
    localparam logic [3:0] BAYER4 [4][4] = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6 },
        '{4'd3,  4'd11, 4'd1,  4'd9 },
        '{4'd15, 4'd7,  4'd13, 4'd5 }
    };

    // One extra bit holds the carry; any carry means the sum passed 63.
    function automatic logic [CW_IN-1:0] sat_add(input logic [CW_IN-1:0]  c,
                                                 input logic [CW_OUT-1:0] t);
        logic [CW_IN:0] s;
        s = {1'b0, c} + {{(CW_IN + 1 - CW_OUT){1'b0}}, t};
        return s[CW_IN] ? {CW_IN{1'b1}} : s[CW_IN-1:0];
    endfunction

endpackage

// File: rtl/vga_dither_3bit_channel.sv
// One colour channel of the dither stage (purely combinational).
//   c_in  : 6-bit colour from pipeline stage 1
//   t     : 3-bit dither threshold (0 when dithering is off)
//   blank : forces the output to black
//   c_out : 3-bit colour, the top bits of the saturated sum
module dither_channel
    import vga_dither_pkg::*;
(
    input  logic [CW_IN-1:0]  c_in,
    input  logic [CW_OUT-1:0] t,
    input  logic              blank,
    output logic [CW_OUT-1:0] c_out
);

    assign c_out = blank ? '0 : CW_OUT'(sat_add(c_in, t) >> (CW_IN - CW_OUT));

endmodule

// File: rtl/vga_dither_3bit.sv
// Output stage between the colour mixer and the 3-bit-per-channel VGA pins.
// Reduces 6-bit R/G/B to 3 bits with 4x4 ordered dithering (or plain
// truncation when dither_en is low) through a two-stage pipeline that keeps
// colour, blank and both syncs aligned.
//   CLK_50MHZ, RST     : clock, synchronous active-high reset
//   pix_ce             : pixel enable; nothing advances while it is low
//   r_in/g_in/b_in     : 6-bit colour,  blank_in : high outside active area
//   hs_in/vs_in        : syncs, active level set by HS_POL / VS_POL
//   dither_en          : 1 = dither, 0 = truncate
//   VGA_R/G/B          : 3-bit colour, VGA_HSYNC/VGA_VSYNC : delayed syncs
module vga_dither_3bit
    import vga_dither_pkg::*;
#(
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter bit TEMPORAL = 1'b0
) (
    input  logic              CLK_50MHZ,
    input  logic              RST,
    input  logic              pix_ce,
    input  logic [CW_IN-1:0]  r_in,
    input  logic [CW_IN-1:0]  g_in,
    input  logic [CW_IN-1:0]  b_in,
    input  logic              blank_in,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              dither_en,
    output logic [CW_OUT-1:0] VGA_R,
    output logic [CW_OUT-1:0] VGA_G,
    output logic [CW_OUT-1:0] VGA_B,
    output logic              VGA_HSYNC,
    output logic              VGA_VSYNC
);

    // Phase counters
    logic [1:0] x_ph_q, x_ph_d;
    logic [1:0] y_ph_q, y_ph_d;
    logic       frame_q, frame_d;

    // Stage 1. hs1_q/vs1_q double as the previous-sync registers used by
    // the edge detectors: both are hs_in/vs_in captured on pix_ce.
    logic [CW_IN-1:0]  r1_q, g1_q, b1_q;
    logic              blank1_q, hs1_q, vs1_q;
    logic [CW_OUT-1:0] t1_q, t_d;

    // Stage 2
    logic [CW_OUT-1:0] r2_q, g2_q, b2_q;
    logic              hs2_q, vs2_q;
    logic [CW_OUT-1:0] r_dith, g_dith, b_dith;

    logic              hs_edge, vs_edge;
    logic [CW_OUT-1:0] t_base, t_temp;

    assign hs_edge = pix_ce && (hs_in == HS_POL) && (hs1_q != HS_POL);
    assign vs_edge = pix_ce && (vs_in == VS_POL) && (vs1_q != VS_POL);

    always_comb begin
        x_ph_d  = x_ph_q;
        y_ph_d  = y_ph_q;
        frame_d = frame_q;
        if (pix_ce) begin
            x_ph_d = hs_edge ? 2'd0 : x_ph_q + 2'd1;
            // A vsync edge restarts the row phase even if hsync also fired.
            if (vs_edge) begin
                y_ph_d  = 2'd0;
                frame_d = ~frame_q;
            end else if (hs_edge) begin
                y_ph_d = y_ph_q + 2'd1;
            end
        end
    end

    // Threshold from the counters as they stand before this pixel's update.
    always_comb begin
        t_base = CW_OUT'(BAYER4[y_ph_q][x_ph_q] >> 1);
        t_temp = (TEMPORAL && frame_q) ? (3'd7 - t_base) : t_base;
        t_d    = dither_en ? t_temp : '0;
    end

    dither_channel u_ch_r (.c_in(r1_q), .t(t1_q), .blank(blank1_q), .c_out(r_dith));
    dither_channel u_ch_g (.c_in(g1_q), .t(t1_q), .blank(blank1_q), .c_out(g_dith));
    dither_channel u_ch_b (.c_in(b1_q), .t(t1_q), .blank(blank1_q), .c_out(b_dith));

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            x_ph_q   <= 2'd0;
            y_ph_q   <= 2'd0;
            frame_q  <= 1'b0;
            r1_q     <= '0;
            g1_q     <= '0;
            b1_q     <= '0;
            blank1_q <= 1'b1;
            hs1_q    <= ~HS_POL;
            vs1_q    <= ~VS_POL;
            t1_q     <= '0;
            r2_q     <= '0;
            g2_q     <= '0;
            b2_q     <= '0;
            hs2_q    <= ~HS_POL;
            vs2_q    <= ~VS_POL;
        end else begin
            x_ph_q  <= x_ph_d;
            y_ph_q  <= y_ph_d;
            frame_q <= frame_d;
            if (pix_ce) begin
                r1_q     <= r_in;
                g1_q     <= g_in;
                b1_q     <= b_in;
                blank1_q <= blank_in;
                hs1_q    <= hs_in;
                vs1_q    <= vs_in;
                t1_q     <= t_d;
                r2_q     <= r_dith;
                g2_q     <= g_dith;
                b2_q     <= b_dith;
                hs2_q    <= hs1_q;
                vs2_q    <= vs1_q;
            end
        end
    end

    assign VGA_R     = r2_q;
    assign VGA_G     = g2_q;
    assign VGA_B     = b2_q;
    assign VGA_HSYNC = hs2_q;
    assign VGA_VSYNC = vs2_q;

endmodule

// File: tb/tb_vga_dither_3bit.sv
// Bench for vga_dither_3bit: one instance with TEMPORAL=0, one with
// TEMPORAL=1, driven by the same pixel stream. Each pixel's expected output
// for both instances is pushed when it is driven and popped two pix_ce later.
module tb_vga_dither_3bit;

    // Observation word: {hsync, vsync, R[2:0], G[2:0], B[2:0]}
    localparam logic [10:0] RST_EXP = 11'b11_000_000_000;

    logic       clk;
    logic       rst;
    logic       pix_ce;
    logic [5:0] r_in, g_in, b_in;
    logic       blank_in, hs_in, vs_in, dither_en;

    logic [2:0] r0, g0, b0, r1, g1, b1;
    logic       hs0, vs0, hs1, vs1;
    logic [10:0] obs0, obs1;

    assign obs0 = {hs0, vs0, r0, g0, b0};
    assign obs1 = {hs1, vs1, r1, g1, b1};

    vga_dither_3bit u_dut0 (
        .CLK_50MHZ(clk), .RST(rst), .pix_ce(pix_ce),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .blank_in(blank_in),
        .hs_in(hs_in), .vs_in(vs_in), .dither_en(dither_en),
        .VGA_R(r0), .VGA_G(g0), .VGA_B(b0), .VGA_HSYNC(hs0), .VGA_VSYNC(vs0)
    );

    vga_dither_3bit #(.TEMPORAL(1'b1)) u_dut1 (
        .CLK_50MHZ(clk), .RST(rst), .pix_ce(pix_ce),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .blank_in(blank_in),
        .hs_in(hs_in), .vs_in(vs_in), .dither_en(dither_en),
        .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .VGA_HSYNC(hs1), .VGA_VSYNC(vs1)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [21:0] exp_q[$];
    logic [21:0] last_exp;
    int          n_cmp;
    int          n_fail;

    // Threshold rows (y) listed in x order.
    int tt [4][4] = '{'{0, 4, 1, 5}, '{6, 2, 7, 3}, '{1, 5, 0, 4}, '{7, 3, 6, 2}};

    // Reference phase state
    int   mx, my;
    bit   mframe;
    logic m_hs_prev, m_vs_prev;

    function automatic logic [2:0] ch(input int c, input int t, input logic bl);
        int s;
        if (bl) return 3'd0;
        s = c + t;
        if (s > 63) s = 63;
        return 3'(s / 8);
    endfunction

    task automatic check_out(input string tag, input logic [21:0] e);
        n_cmp++;
        assert (obs0 === e[21:11]) else begin
            n_fail++;
            $error("FAIL %s dut0: observed %h expected %h", tag, obs0, e[21:11]);
        end
        n_cmp++;
        assert (obs1 === e[10:0]) else begin
            n_fail++;
            $error("FAIL %s dut1: observed %h expected %h", tag, obs1, e[10:0]);
        end
    endtask

    // Stage 1 after reset holds blank with idle syncs; that is the first
    // thing to come out once pixels start flowing.
    task automatic model_reset();
        mx = 0;
        my = 0;
        mframe = 1'b0;
        m_hs_prev = 1'b1;
        m_vs_prev = 1'b1;
        exp_q.delete();
        exp_q.push_back({RST_EXP, RST_EXP});
        last_exp = {RST_EXP, RST_EXP};
    endtask

    task automatic randomize_inputs();
        r_in      = 6'($urandom_range(0, 63));
        g_in      = 6'($urandom_range(0, 63));
        b_in      = 6'($urandom_range(0, 63));
        blank_in  = 1'($urandom_range(0, 1));
        hs_in     = 1'($urandom_range(0, 1));
        vs_in     = 1'($urandom_range(0, 1));
        dither_en = 1'($urandom_range(0, 1));
    endtask

    // Drive one pixel (one pix_ce), then hold for 'gap' idle clocks.
    task automatic pix(input logic [5:0] ri, input logic [5:0] gi, input logic [5:0] bi,
                       input logic bl, input logic hsi, input logic vsi, input logic dei,
                       input int gap, input string tag);
        int   t0, t1;
        logic hs_e, vs_e;
        logic [21:0] e;
        r_in = ri; g_in = gi; b_in = bi;
        blank_in = bl; hs_in = hsi; vs_in = vsi; dither_en = dei;
        pix_ce = 1'b1;

        hs_e = (hsi == 1'b0) && (m_hs_prev == 1'b1);
        vs_e = (vsi == 1'b0) && (m_vs_prev == 1'b1);
        t0 = tt[my][mx];
        t1 = mframe ? 7 - t0 : t0;
        if (!dei) begin
            t0 = 0;
            t1 = 0;
        end
        exp_q.push_back({hsi, vsi, ch(ri, t0, bl), ch(gi, t0, bl), ch(bi, t0, bl),
                         hsi, vsi, ch(ri, t1, bl), ch(gi, t1, bl), ch(bi, t1, bl)});
        mx = hs_e ? 0 : (mx + 1) % 4;
        if (vs_e) begin
            my = 0;
            mframe = ~mframe;
        end else if (hs_e) begin
            my = (my + 1) % 4;
        end
        m_hs_prev = hsi;
        m_vs_prev = vsi;

        @(posedge clk);
        #1;
        pix_ce = 1'b0;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            last_exp = e;
            check_out(tag, e);
        end
        for (int k = 0; k < gap; k++) begin
            randomize_inputs();
            @(posedge clk);
            #1;
            check_out({tag, "_hold"}, last_exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        pix_ce = 1'b0;
        randomize_inputs();
        model_reset();

        // Reset held 3 clocks with inputs toggling.
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            pix_ce = 1'b1;
            @(posedge clk);
            #1;
            check_out("reset", {RST_EXP, RST_EXP});
        end
        rst = 1'b0;
        pix_ce = 1'b0;
        model_reset();

        pix(6'h10, 6'h20, 6'h30, 1'b1, 1'b1, 1'b1, 1'b1, 0, "idle");
        pix(6'h10, 6'h20, 6'h30, 1'b1, 1'b1, 1'b1, 1'b1, 0, "idle");

        // Row 0 twice: simultaneous hs/vs edge then 4 pixels r=0x04.
        // The second pass returns TEMPORAL instance to frame 0.
        for (int f = 0; f < 2; f++) begin
            pix(6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 0, "row0_edge");
            for (int x = 0; x < 4; x++)
                pix(6'h04, 6'h00, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1, 0, "row0");
        end

        // Saturation at full scale and zero across all 16 phases.
        for (int v = 0; v < 2; v++) begin
            pix(6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 1'b1, 0, "sat_vedge");
            for (int y = 0; y < 4; y++) begin
                if (y > 0)
                    pix(6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b1, 1'b1, 0, "sat_hedge");
                for (int x = 0; x < 4; x++)
                    pix(6'($urandom_range(0, 63)), (v == 0) ? 6'h3F : 6'h00,
                        6'($urandom_range(0, 63)), 1'b0, 1'b1, 1'b1, 1'b1, 0,
                        (v == 0) ? "sat_max" : "sat_zero");
            end
        end

        // Truncation: b swept 0..63 with hsync edges mixed in.
        for (int i = 0; i < 64; i++)
            pix(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 6'(i),
                1'b0, (i % 8 == 0) ? 1'b0 : 1'b1, 1'b1, 1'b0, 0, "trunc");

        // Alignment: pix_ce every 2nd clock, multi-pixel hsync pulses,
        // blank toggling, one simultaneous hs/vs edge.
        for (int k = 0; k < 40; k++)
            pix(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                6'($urandom_range(0, 63)),
                ((k % 10) < 3) || (k % 7 == 0),
                ((k % 10) < 3) ? 1'b0 : 1'b1,
                (k == 20 || k == 21) ? 1'b0 : 1'b1,
                1'($urandom_range(0, 1)), 1, "align");

        // Reset in mid-line.
        pix(6'h3F, 6'h3F, 6'h3F, 1'b0, 1'b1, 1'b1, 1'b1, 0, "pre_rst");
        pix(6'h3F, 6'h3F, 6'h3F, 1'b0, 1'b0, 1'b1, 1'b1, 0, "pre_rst");
        rst = 1'b1;
        randomize_inputs();
        pix_ce = 1'b1;
        @(posedge clk);
        #1;
        check_out("midline_reset", {RST_EXP, RST_EXP});
        rst = 1'b0;
        pix_ce = 1'b0;
        model_reset();
        for (int k = 0; k < 12; k++)
            pix(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                (k == 3) ? 1'b0 : 1'b1, 1'b1, 1'b1, 0, "post_rst");

        // Drain the pipeline.
        pix(6'h00, 6'h00, 6'h00, 1'b1, 1'b1, 1'b1, 1'b0, 0, "drain");
        pix(6'h00, 6'h00, 6'h00, 1'b1, 1'b1, 1'b1, 1'b0, 0, "drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
